// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants for the pipeline-stage register slice.
//   DATA_W_DEF / WE_W_DEF : default payload and write-enable widths.
//   STAT_W                : width of the optional statistics counters.
//   WE_*                  : bit positions inside the standard write-enable vector.
package pipe_pkg;

    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned WE_W_DEF   = 4;
    localparam int unsigned STAT_W     = 32;

    localparam int unsigned WE_WREG  = 0;
    localparam int unsigned WE_WHILO = 1;
    localparam int unsigned WE_LLBIT = 2;
    localparam int unsigned WE_CP0   = 3;

endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one valid + payload + write-enable register.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (clears everything)
//   clr_i      : synchronous clear, same effect as rst (flush)
//   load_i     : capture data_i/we_i and mark the slot valid
//   drop_i     : mark the slot empty, payload is kept
//   data_i/we_i: incoming payload and write enables
//   valid_o/data_o/we_o: registered slot contents
module pipe_slot #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned WE_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [WE_W-1:0]   we_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [WE_W-1:0]   we_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [WE_W-1:0]   we_q,    we_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        we_d    = we_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            we_d    = we_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            we_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            we_q    <= we_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign we_o    = we_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic pipeline-stage register with valid/ready handshake.
// Parameters:
//   DATA_W      : payload width
//   WE_W        : write-enable vector width
//   SKID_EN     : 1 = main + skid entry, registered in_ready; 0 = single entry
//   ZERO_BUBBLE : 1 = out_data forced to zero while out_valid is low
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   flush                        : drop all held entries
//   in_valid/in_ready/in_data/in_we     : upstream handshake and payload
//   out_valid/out_ready/out_data/out_we : downstream handshake and payload
// Optional (macro PIPE_STAGE_BUF_STAT_EN):
//   stat_stall  : saturating count of cycles with out_valid & ~out_ready
//   stat_bubble : saturating count of cycles with ~out_valid
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WE_W        = WE_W_DEF,
    parameter bit          SKID_EN     = 1'b1,
    parameter bit          ZERO_BUBBLE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [WE_W-1:0]   in_we,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [WE_W-1:0]   out_we
`ifdef PIPE_STAGE_BUF_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_stall,
    output logic [STAT_W-1:0] stat_bubble
`endif
);

    logic              m_valid, s_valid;
    logic [DATA_W-1:0] m_data,  s_data;
    logic [WE_W-1:0]   m_we,    s_we;

    logic              in_fire, out_fire;
    logic              m_load, m_drop, s_load, s_drop;
    logic [DATA_W-1:0] m_src_data;
    logic [WE_W-1:0]   m_src_we;

    generate
        if (SKID_EN) begin : g_rdy_skid
            assign in_ready = ~rst & ~flush & ~s_valid;
        end else begin : g_rdy_single
            assign in_ready = ~rst & ~flush & (~m_valid | out_ready);
        end
    endgenerate

    assign in_fire  = in_valid & in_ready;
    assign out_fire = m_valid & out_ready;

    // With SKID_EN=0 s_valid is tied low and a fire into a full, stalled main
    // cannot happen, so the same control equations serve both variants.
    always_comb begin
        m_load     = 1'b0;
        m_drop     = 1'b0;
        s_load     = 1'b0;
        s_drop     = 1'b0;
        m_src_data = in_data;
        m_src_we   = in_we;
        if (s_valid) begin
            // Skid refills main as soon as downstream takes the main entry.
            m_load     = out_fire;
            s_drop     = out_fire;
            m_src_data = s_data;
            m_src_we   = s_we;
        end else begin
            m_load = in_fire & (~m_valid | out_fire);
            m_drop = out_fire & ~in_fire;
            s_load = in_fire & m_valid & ~out_fire;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .WE_W(WE_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .load_i  (m_load),
        .drop_i  (m_drop),
        .data_i  (m_src_data),
        .we_i    (m_src_we),
        .valid_o (m_valid),
        .data_o  (m_data),
        .we_o    (m_we)
    );

    generate
        if (SKID_EN) begin : g_skid
            pipe_slot #(.DATA_W(DATA_W), .WE_W(WE_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .clr_i   (flush),
                .load_i  (s_load),
                .drop_i  (s_drop),
                .data_i  (in_data),
                .we_i    (in_we),
                .valid_o (s_valid),
                .data_o  (s_data),
                .we_o    (s_we)
            );
        end else begin : g_no_skid
            assign s_valid = 1'b0;
            assign s_data  = '0;
            assign s_we    = '0;
        end
    endgenerate

    assign out_valid = m_valid;
    assign out_we    = m_we & {WE_W{m_valid}};
    assign out_data  = (ZERO_BUBBLE && !m_valid) ? '0 : m_data;

`ifdef PIPE_STAGE_BUF_STAT_EN
    logic [STAT_W-1:0] stat_stall_q, stat_bubble_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall_q  <= '0;
            stat_bubble_q <= '0;
        end else begin
            if (m_valid && !out_ready && !(&stat_stall_q))
                stat_stall_q <= stat_stall_q + STAT_W'(1);
            if (!m_valid && !(&stat_bubble_q))
                stat_bubble_q <= stat_bubble_q + STAT_W'(1);
        end
    end

    assign stat_stall  = stat_stall_q;
    assign stat_bubble = stat_bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: drives a SKID_EN=1/ZERO_BUBBLE=1 instance (suffix 1) and a
// SKID_EN=0/ZERO_BUBBLE=0 instance (suffix 0) from shared stimulus. Each
// instance is modelled as a bounded FIFO (capacity 2 or 1) built on a queue.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int unsigned DW = 64;
    localparam int unsigned WW = 4;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic [WW-1:0] in_we;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DW-1:0] out_data1, out_data0;
    logic [WW-1:0] out_we1, out_we0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [WW-1:0] we;
    } ent_t;

    ent_t          q1[$];
    ent_t          q0[$];
    logic [DW-1:0] last0;

`ifdef PIPE_STAGE_BUF_STAT_EN
    logic [STAT_W-1:0] stat_stall1, stat_bubble1, stat_stall0, stat_bubble0;
`endif

    always #5 clk = ~clk;

    pipe_stage_buf #(.DATA_W(DW), .WE_W(WW), .SKID_EN(1'b1), .ZERO_BUBBLE(1'b1)) dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_we(in_we),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_we(out_we1)
`ifdef PIPE_STAGE_BUF_STAT_EN
        , .stat_stall(stat_stall1), .stat_bubble(stat_bubble1)
`endif
    );

    pipe_stage_buf #(.DATA_W(DW), .WE_W(WW), .SKID_EN(1'b0), .ZERO_BUBBLE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_we(in_we),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_we(out_we0)
`ifdef PIPE_STAGE_BUF_STAT_EN
        , .stat_stall(stat_stall0), .stat_bubble(stat_bubble0)
`endif
    );

    // Advance the reference FIFOs across one rising edge using the inputs
    // currently applied.
    task automatic step();
        bit   r1, r0;
        ent_t e;
        r1   = !rst && !flush && (q1.size() < 2);
        r0   = !rst && !flush && (q0.size() == 0 || out_ready);
        e.d  = in_data;
        e.we = in_we;
        @(posedge clk);
        if (rst || flush) begin
            q1.delete();
            q0.delete();
            last0 = '0;
        end else begin
            if (q1.size() > 0 && out_ready) void'(q1.pop_front());
            if (in_valid && r1) q1.push_back(e);
            if (q0.size() > 0 && out_ready) void'(q0.pop_front());
            if (in_valid && r0) begin
                q0.push_back(e);
                last0 = in_data;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            flush     = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; in_valid = 1'b1; in_data = 64'hDEAD; in_we = '1;
            #1;
            checks++;
            if (out_valid1 !== 1'b0 || out_data1 !== '0 || out_we1 !== '0 || in_ready1 !== 1'b0) begin
                errors++;
                $display("FAIL reset_dut1: valid=%b data=%h we=%b in_ready=%b, required 0/0/0/0",
                         out_valid1, out_data1, out_we1, in_ready1);
            end
            checks++;
            if (out_valid0 !== 1'b0 || out_data0 !== '0 || out_we0 !== '0 || in_ready0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_dut0: valid=%b data=%h we=%b in_ready=%b, required 0/0/0/0",
                         out_valid0, out_data0, out_we0, in_ready0);
            end
            step();
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready1=%b in_ready0=%b, required 1/1", in_ready1, in_ready0);
        end
        step();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (i > 1) begin
                checks++;
                if (out_valid1 !== 1'b1 || out_data1 !== DW'(i - 1) || out_we1 !== 4'b0001) begin
                    errors++;
                    $display("FAIL stream_dut1[%0d]: valid=%b data=%h we=%b, required 1/%h/0001",
                             i - 1, out_valid1, out_data1, out_we1, DW'(i - 1));
                end
                checks++;
                if (out_valid0 !== 1'b1 || out_data0 !== DW'(i - 1) || out_we0 !== 4'b0001) begin
                    errors++;
                    $display("FAIL stream_dut0[%0d]: valid=%b data=%h we=%b, required 1/%h/0001",
                             i - 1, out_valid0, out_data0, out_we0, DW'(i - 1));
                end
            end
            in_valid = (i <= 8);
            in_data  = DW'(i);
            in_we    = 4'b0001;
            step();
        end
        idle(3);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h11; in_we = 4'b0011;
        step();
        @(negedge clk);
        in_data = 64'h22; in_we = 4'b0101;
        #1;
        checks++;
        if (in_ready1 !== 1'b1) begin
            errors++;
            $display("FAIL bp_skid_free: in_ready=%b, required 1", in_ready1);
        end
        step();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready1 !== 1'b0 || out_data1 !== 64'h11 || out_we1 !== 4'b0011) begin
            errors++;
            $display("FAIL bp_full: in_ready=%b data=%h we=%b, required 0/11/0011", in_ready1, out_data1, out_we1);
        end
        out_ready = 1'b1;
        step();
        @(negedge clk);
        #1;
        checks++;
        if (in_ready1 !== 1'b1 || out_valid1 !== 1'b1 || out_data1 !== 64'h22 || out_we1 !== 4'b0101) begin
            errors++;
            $display("FAIL bp_b_in_main: in_ready=%b valid=%b data=%h we=%b, required 1/1/22/0101",
                     in_ready1, out_valid1, out_data1, out_we1);
        end
        step();
        @(negedge clk);
        #1;
        checks++;
        if (out_valid1 !== 1'b0 || out_we1 !== '0 || out_data1 !== '0) begin
            errors++;
            $display("FAIL bp_drained: valid=%b we=%b data=%h, required 0/0/0", out_valid1, out_we1, out_data1);
        end
        step();
        idle(2);
    endtask

    task automatic test_single_stall();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h44; in_we = 4'b1000;
        step();
        @(negedge clk);
        in_data = 64'h55; in_we = 4'b0100;
        #1;
        checks++;
        if (in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL single_stall_ready: in_ready=%b, required 0", in_ready0);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b1 || out_data0 !== 64'h44) begin
            errors++;
            $display("FAIL single_release_ready: in_ready=%b data=%h, required 1/44", in_ready0, out_data0);
        end
        step();
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid0 !== 1'b1 || out_data0 !== 64'h55 || out_we0 !== 4'b0100) begin
            errors++;
            $display("FAIL single_replace: valid=%b data=%h we=%b, required 1/55/0100", out_valid0, out_data0, out_we0);
        end
        step();
        @(negedge clk);
        #1;
        checks++;
        if (out_valid0 !== 1'b0 || out_we0 !== '0 || out_data0 !== 64'h55) begin
            errors++;
            $display("FAIL single_hold_data: valid=%b we=%b data=%h, required 0/0/55", out_valid0, out_we0, out_data0);
        end
        step();
        idle(2);
    endtask

    task automatic test_flush();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'hA1; in_we = 4'b1111;
        step();
        @(negedge clk);
        in_data = 64'hA2;
        step();
        @(negedge clk);
        flush = 1'b1; in_data = 64'h33;
        #1;
        checks++;
        if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: in_ready1=%b in_ready0=%b, required 0/0", in_ready1, in_ready0);
        end
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            #1;
            checks++;
            if (out_valid1 !== 1'b0 || out_we1 !== '0 || out_data1 === 64'h33 ||
                out_valid0 !== 1'b0 || out_we0 !== '0) begin
                errors++;
                $display("FAIL flush_empty[%0d]: v1=%b we1=%b d1=%h v0=%b we0=%b, required 0/0/not33/0/0",
                         i, out_valid1, out_we1, out_data1, out_valid0, out_we0);
            end
            step();
        end
    endtask

    task automatic test_random();
        logic          ev1, ev0, er1, er0;
        logic [DW-1:0] ed1, ed0;
        logic [WW-1:0] ew1, ew0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 79) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom};
            in_we     = WW'($urandom);
            #1;
            ev1 = (q1.size() != 0);
            ed1 = ev1 ? q1[0].d  : '0;
            ew1 = ev1 ? q1[0].we : '0;
            er1 = !rst && !flush && (q1.size() < 2);
            ev0 = (q0.size() != 0);
            ed0 = ev0 ? q0[0].d  : last0;
            ew0 = ev0 ? q0[0].we : '0;
            er0 = !rst && !flush && (!ev0 || out_ready);
            checks++;
            if (out_valid1 !== ev1 || out_data1 !== ed1 || out_we1 !== ew1 || in_ready1 !== er1) begin
                errors++;
                $display("FAIL random_dut1[%0d]: v=%b d=%h we=%b rdy=%b, required %b/%h/%b/%b",
                         c, out_valid1, out_data1, out_we1, in_ready1, ev1, ed1, ew1, er1);
            end
            checks++;
            if (out_valid0 !== ev0 || out_data0 !== ed0 || out_we0 !== ew0 || in_ready0 !== er0) begin
                errors++;
                $display("FAIL random_dut0[%0d]: v=%b d=%h we=%b rdy=%b, required %b/%h/%b/%b",
                         c, out_valid0, out_data0, out_we0, in_ready0, ev0, ed0, ew0, er0);
            end
            step();
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        step();
        idle(3);
    endtask

`ifdef PIPE_STAGE_BUF_STAT_EN
    task automatic test_stats();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        step();
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h77; in_we = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            step();
        end
        @(negedge clk);
        #1;
        checks++;
        if (stat_stall1 !== 32'd5) begin
            errors++;
            $display("FAIL stat_stall: got %0d, required 5", stat_stall1);
        end
        out_ready = 1'b1;
        step();
        idle(3);
        @(negedge clk);
        #1;
        checks++;
        if (stat_bubble1 < 32'd3) begin
            errors++;
            $display("FAIL stat_bubble: got %0d, required >=3", stat_bubble1);
        end
        out_ready = 1'b0; in_valid = 1'b1;
        step();
        @(negedge clk);
        in_valid = 1'b0;
        force dut1.stat_stall_q = '1;
        #1;
        release dut1.stat_stall_q;
        step();
        @(negedge clk);
        #1;
        checks++;
        if (stat_stall1 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stat_saturate: got %h, required ffffffff", stat_stall1);
        end
        out_ready = 1'b1;
        step();
        idle(2);
    endtask
`endif

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_we = '0; last0 = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_single_stall();
        test_flush();
        test_random();
`ifdef PIPE_STAGE_BUF_STAT_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
